instr_fetch_unit: RTL

- Upstream stage of the 8-bit instruction memory.
- Generates the program counter that addresses the memory and captures the returned instruction into an instruction register.
- Presents that register to the downstream decode/move stage through a valid/ready handshake, with the MOV register fields split out.
- Stops cleanly after a fixed program length and holds in a halted state until reset.

---
 rtl/instr_fetch_unit_if.sv | 30 +++
 rtl/instr_fetch_unit.sv | 119 +++++++++++
 2 files changed

// File: rtl/instr_fetch_unit_if.sv
// ============================================================================
// instr_fetch_unit_if : memory-address and instruction-register handshake bus
// Rev 1.0
// ============================================================================
`default_nettype none

interface instr_fetch_unit_if #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 8
);
  logic [PC_WIDTH-1:0]      pc;
  logic [INSTR_WIDTH-1:0]   instr_in;
  logic [INSTR_WIDTH-1:0]   ir_out;
  logic                     ir_valid;
  logic                     ir_ready;
  logic [INSTR_WIDTH/2-1:0] dst_reg;
  logic [INSTR_WIDTH/2-1:0] src_reg;

  modport master (
    output pc, ir_out, ir_valid, dst_reg, src_reg,
    input  instr_in, ir_ready
  );

  modport slave (
    input  pc, ir_out, ir_valid, dst_reg, src_reg,
    output instr_in, ir_ready
  );
endinterface

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// instr_fetch_unit : PC generator and instruction register with valid/ready
// Rev 1.0
// ============================================================================
`default_nettype none

module instr_fetch_unit #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 8,
  parameter int PROG_LEN    = 3,
  parameter int RESET_PC    = 0
) (
  input  wire                      clk,
  input  wire                      reset,
  input  wire                      enable,
  output logic                     halted,
  output logic [PC_WIDTH-1:0]      fetch_count,
  instr_fetch_unit_if.master       bus
);

  localparam int HALF = INSTR_WIDTH / 2;

  localparam logic [1:0] c_idle  = 2'd0;
  localparam logic [1:0] c_fetch = 2'd1;
  localparam logic [1:0] c_drain = 2'd2;
  localparam logic [1:0] c_halt  = 2'd3;

  localparam logic [PC_WIDTH-1:0] c_prog_len  = PC_WIDTH'(PROG_LEN);
  localparam logic [PC_WIDTH-1:0] c_last_addr = (PROG_LEN == 0) ? '0 : PC_WIDTH'(PROG_LEN - 1);
  localparam logic [PC_WIDTH-1:0] c_reset_pc  = PC_WIDTH'(RESET_PC);
  localparam logic [PC_WIDTH-1:0] c_cnt_max   = '1;

  logic [1:0]             r_state;
  logic [1:0]             w_state_next;
  logic [PC_WIDTH-1:0]    r_pc;
  logic [INSTR_WIDTH-1:0] r_ir;
  logic                   r_ir_valid;
  logic [PC_WIDTH-1:0]    r_fetch_count;

  logic w_transfer;
  logic w_slot_free;
  logic w_capture;
  logic w_last;
  logic w_halted;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_idle: begin
        if (enable) begin
          w_state_next = (PROG_LEN == 0) ? c_halt : c_fetch;
        end
      end
      c_fetch: begin
        if (!enable) begin
          w_state_next = c_idle;
        end else if (w_capture && w_last) begin
          w_state_next = c_drain;
        end
      end
      c_drain: begin
        if (w_transfer) begin
          w_state_next = c_halt;
        end
      end
      c_halt:  w_state_next = c_halt;
      default: w_state_next = c_idle;
    endcase
  end

  // Output / strobe logic; the pc bound guard keeps addresses >= PROG_LEN uncaptured
  always_comb begin
    w_transfer  = r_ir_valid && bus.ir_ready;
    w_slot_free = !r_ir_valid || bus.ir_ready;
    w_last      = (r_pc == c_last_addr);
    w_capture   = (r_state == c_fetch) && enable && w_slot_free && (r_pc < c_prog_len);
    w_halted    = (r_state == c_halt);
  end

  // Datapath: pc, instruction register, valid flag and saturating capture count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc          <= c_reset_pc;
      r_ir          <= '0;
      r_ir_valid    <= 1'b0;
      r_fetch_count <= '0;
    end else begin
      if (w_capture) begin
        r_pc          <= r_pc + 1'b1;
        r_ir          <= bus.instr_in;
        r_ir_valid    <= 1'b1;
        r_fetch_count <= (r_fetch_count == c_cnt_max) ? r_fetch_count : r_fetch_count + 1'b1;
      end else if (w_transfer) begin
        r_ir_valid <= 1'b0;
      end
    end
  end

  assign bus.pc       = r_pc;
  assign bus.ir_out   = r_ir;
  assign bus.ir_valid = r_ir_valid;
  assign bus.dst_reg  = r_ir[INSTR_WIDTH-1 -: HALF];
  assign bus.src_reg  = r_ir[HALF-1:0];
  assign halted       = w_halted;
  assign fetch_count  = r_fetch_count;

endmodule

`default_nettype wire
